// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite memory slave: one outstanding transaction, byte-strobed writes, registered reads.
// Optional macro AXI_MEM_RANGE_CHECK_EN: addresses beyond MEM_DEPTH words get SLVERR instead of aliasing.
module axi4_lite_mem_slave #(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int         IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_WAIT_DATA, WR_WAIT_ADDR, WR_RESP, RD_RESP} state_t;

    state_t                state;
    logic [31:0]           mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;

    logic                  wr_go;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_oor, rd_oor;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  unused_addr_bits;

    // Whichever half of the write arrives last completes it; the other half comes from the latch.
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_arready = 1'b0;
        wr_go         = 1'b0;
        wr_addr       = s_axi_awaddr;
        wr_data       = s_axi_wdata;
        wr_strb       = s_axi_wstrb;
        case (state)
            IDLE: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                s_axi_arready = ~s_axi_awvalid & ~s_axi_wvalid;
                wr_go         = s_axi_awvalid & s_axi_wvalid;
            end
            WR_WAIT_DATA: begin
                s_axi_wready = 1'b1;
                wr_go        = s_axi_wvalid;
                wr_addr      = aw_addr_q;
            end
            WR_WAIT_ADDR: begin
                s_axi_awready = 1'b1;
                wr_go         = s_axi_awvalid;
                wr_data       = w_data_q;
                wr_strb       = w_strb_q;
            end
            default: ;
        endcase
    end

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign wr_oor = |(wr_addr >> (IDX_W + 2));
    assign rd_oor = |(s_axi_araddr >> (IDX_W + 2));
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    assign wr_idx           = wr_addr[IDX_W+1:2];
    assign rd_idx           = s_axi_araddr[IDX_W+1:2];
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr, aw_addr_q};

    // Memory has no reset; a write coinciding with reset is dropped along with its transaction.
    always_ff @(posedge clk) begin
        if (rst && wr_go && !wr_oor) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_strb[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_bresp  <= OKAY;
            s_axi_rresp  <= OKAY;
            s_axi_rdata  <= '0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_awvalid && s_axi_wvalid) begin
                        state        <= WR_RESP;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= wr_oor ? SLVERR : OKAY;
                    end else if (s_axi_awvalid) begin
                        state     <= WR_WAIT_DATA;
                        aw_addr_q <= s_axi_awaddr;
                    end else if (s_axi_wvalid) begin
                        state    <= WR_WAIT_ADDR;
                        w_data_q <= s_axi_wdata;
                        w_strb_q <= s_axi_wstrb;
                    end else if (s_axi_arvalid) begin
                        state        <= RD_RESP;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rresp  <= rd_oor ? SLVERR : OKAY;
                        s_axi_rdata  <= rd_oor ? 32'd0 : mem[rd_idx];
                    end
                end
                WR_WAIT_DATA, WR_WAIT_ADDR: begin
                    if (wr_go) begin
                        state        <= WR_RESP;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= wr_oor ? SLVERR : OKAY;
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        state        <= IDLE;
                        s_axi_bvalid <= 1'b0;
                    end
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        state        <= IDLE;
                        s_axi_rvalid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi4_lite_mem_slave.md
AXI4_LITE_MEM_SLAVE -- requirements
Module: axi4_lite_mem_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024: data memory size in 32-bit words; power of two, 16..16384.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port s_axi_awaddr, input, ADDR_WIDTH bits: write address. s_axi_awvalid is an input (1 bit); s_axi_awready is an output (1 bit).
REQ-006 SHALL have port s_axi_wdata, input, 32 bits: write data. s_axi_wstrb is an input (4 bits, byte-lane enables); s_axi_wvalid is an input (1 bit); s_axi_wready is an output (1 bit).
REQ-007 SHALL have port s_axi_bresp, output, 2 bits: write response. s_axi_bvalid is an output (1 bit); s_axi_bready is an input (1 bit).
REQ-008 SHALL have port s_axi_araddr, input, ADDR_WIDTH bits: read address. s_axi_arvalid is an input (1 bit); s_axi_arready is an output (1 bit).
REQ-009 SHALL have port s_axi_rdata, output, 32 bits: read data. s_axi_rresp is an output (2 bits); s_axi_rvalid is an output (1 bit); s_axi_rready is an input (1 bit).

Function
REQ-010 SHALL implement FSM states IDLE, WR_WAIT_DATA, WR_WAIT_ADDR, WR_RESP and RD_RESP, with one outstanding transaction at a time.
REQ-011 In IDLE: awready=1, wready=1, arready = ~awvalid & ~wvalid (writes take priority over a simultaneous read).
REQ-012 IDLE, AW and W handshake in the same cycle: memory write at that edge; next state WR_RESP.
REQ-013 IDLE, AW handshake only: latch awaddr; next state WR_WAIT_DATA (wready=1, awready=0, arready=0). On the W handshake: write, then go to WR_RESP.
REQ-014 IDLE, W handshake only: latch wdata/wstrb; next state WR_WAIT_ADDR (awready=1, wready=0, arready=0). On the AW handshake: write, then go to WR_RESP.
REQ-015 WR_RESP: bvalid=1 and bresp stable until bready; on the handshake, return to IDLE. All readies are 0.
REQ-016 IDLE, AR handshake: registered memory read; next cycle RD_RESP with rvalid=1.
REQ-017 RD_RESP: rdata/rresp held stable until rready; on the handshake, return to IDLE. All readies are 0.
REQ-018 Latency: AW+W in cycle N gives bvalid in N+1; AR in cycle N gives rvalid in N+1. Minimum 2 cycles per transaction.
REQ-019 Word index = addr[log2(MEM_DEPTH)+1:2]; addr[1:0] is ignored. Byte lane k is written only when wstrb[k]=1; wstrb=0 writes nothing but still returns a response.
REQ-020 A write followed by a read of the same word SHALL return the new data.
REQ-021 bvalid/rvalid SHALL NOT deassert without the matching ready.
REQ-022 Readies SHALL depend combinationally only on state and the awvalid/wvalid inputs.

Reset
REQ-023 rst=0 at a clock edge SHALL set: state IDLE, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, latched address/data/strobe cleared.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 Reset mid-transaction SHALL drop the pending transaction with no response; a write already committed remains.

Configuration
REQ-026 Macro AXI_MEM_RANGE_CHECK_EN defined: any address with an upper bit set above bit log2(MEM_DEPTH)+1 is out of range. An out-of-range write SHALL NOT modify memory and SHALL return bresp=2'b10; an out-of-range read SHALL return rdata=0 and rresp=2'b10.
REQ-027 Macro AXI_MEM_RANGE_CHECK_EN undefined: addresses alias modulo memory size, and bresp/rresp are always 2'b00.

Verification
REQ-028 AW=0x10 and W=0xDEADBEEF with strb=4'hF in the same cycle, bready=1 -> bvalid next cycle, bresp=0. Then AR=0x10 -> rvalid 1 cycle later, rdata=0xDEADBEEF.
REQ-029 W precedes AW by 3 cycles; strb=4'b0010 with wdata=0x0000AB00 to a word holding 0x11223344 -> readback 0x1122AB44.
REQ-030 AR and AW+W asserted together in IDLE -> write accepted first (arready=0). The read then completes and returns the written data.
REQ-031 Hold rready=0 for 5 cycles during RD_RESP -> rvalid and rdata stable throughout; a single handshake when rready rises.
REQ-032 With AXI_MEM_RANGE_CHECK_EN and MEM_DEPTH=1024, write to 0x1000 -> bresp=2'b10 and word 0 unchanged. Without the macro, the same write lands in word 0 with bresp=0.
REQ-033 Assert rst=0 while in WR_RESP -> next cycle bvalid=0 and state IDLE; the written data remains readable.
